// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: reset/bubble defaults, FSM state type, PC increment.
package fetch_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;
    localparam int unsigned PC_INC            = 4;

    typedef enum logic {
        StRun,
        StHalt
    } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: bubble beats stall, stall beats load.
module if_id_reg #(
    parameter int unsigned            ADDRESS_WIDTH = 32,
    parameter int unsigned            DATA_WIDTH    = 32,
    parameter logic [DATA_WIDTH-1:0]  NOP_INSTR     = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     bubble_i,
    input  logic                     stall_i,
    input  logic [DATA_WIDTH-1:0]    instr_i,
    input  logic [ADDRESS_WIDTH-1:0] pc_i,
    input  logic [ADDRESS_WIDTH-1:0] pc_plus4_i,
    output logic [DATA_WIDTH-1:0]    instr_o,
    output logic [ADDRESS_WIDTH-1:0] pc_o,
    output logic [ADDRESS_WIDTH-1:0] pc_plus4_o,
    output logic                     valid_o,
    output logic                     load_o
);

    logic [DATA_WIDTH-1:0]    instr_q, instr_d;
    logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
    logic [ADDRESS_WIDTH-1:0] pc_plus4_q, pc_plus4_d;
    logic                     valid_q, valid_d;

    assign load_o = !bubble_i && !stall_i;

    // A bubble only replaces the instruction; the PC fields keep their last values.
    always_comb begin
        instr_d    = instr_q;
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        if (bubble_i) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (load_o) begin
            instr_d    = instr_i;
            pc_d       = pc_i;
            pc_plus4_d = pc_plus4_i;
            valid_d    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q    <= NOP_INSTR;
            pc_q       <= '0;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    assign instr_o    = instr_q;
    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_plus4_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch stage: PC register, next-PC selection, RUN/HALT FSM, fetch counter and the IF/ID register.
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter int unsigned               ADDRESS_WIDTH = 32,
    parameter int unsigned               DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0]  RESET_PC      = ADDRESS_WIDTH'(DEFAULT_RESET_PC),
    parameter logic [DATA_WIDTH-1:0]     NOP_INSTR     = DATA_WIDTH'(DEFAULT_NOP_INSTR)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall_f,
    input  logic                     stall_d,
    input  logic                     flush_d,
    input  logic                     pc_src_e,
    input  logic [ADDRESS_WIDTH-1:0] pc_target_e,
    output logic [ADDRESS_WIDTH-1:0] instr_addr,
    input  logic [DATA_WIDTH-1:0]    instr_f,
    output logic [DATA_WIDTH-1:0]    instr_d,
    output logic [ADDRESS_WIDTH-1:0] pc_d,
    output logic [ADDRESS_WIDTH-1:0] pc_plus4_d,
    output logic                     valid_d,
    output logic                     halted,
    output logic [31:0]              fetch_cnt
);

    fetch_state_e             state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] pc_f_q, pc_f_d;
    logic [ADDRESS_WIDTH-1:0] pc_plus4_f;
    logic [31:0]              fetch_cnt_q, fetch_cnt_d;
    logic                     misaligned;
    logic                     running;
    logic                     ifid_load;

    assign pc_plus4_f = pc_f_q + ADDRESS_WIDTH'(PC_INC);
    assign misaligned = pc_src_e && (pc_target_e[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == StRun && misaligned) begin
            state_d = StHalt;
        end
    end

    always_comb begin
        running = (state_q == StRun);
        halted  = (state_q == StHalt);
    end

    // Redirect is checked before stall_f so a taken branch is never dropped.
    always_comb begin
        pc_f_d = pc_f_q;
        if (running && !misaligned) begin
            if (pc_src_e) begin
                pc_f_d = pc_target_e;
            end else if (!stall_f) begin
                pc_f_d = pc_plus4_f;
            end
        end
    end

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        if (ifid_load) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_f_q      <= RESET_PC;
            fetch_cnt_q <= '0;
        end else begin
            pc_f_q      <= pc_f_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    if_id_reg #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH),
        .NOP_INSTR     (NOP_INSTR)
    ) u_if_id_reg (
        .clk        (clk),
        .rst        (rst),
        .bubble_i   (halted || flush_d),
        .stall_i    (stall_d),
        .instr_i    (instr_f),
        .pc_i       (pc_f_q),
        .pc_plus4_i (pc_plus4_f),
        .instr_o    (instr_d),
        .pc_o       (pc_d),
        .pc_plus4_o (pc_plus4_d),
        .valid_o    (valid_d),
        .load_o     (ifid_load)
    );

    assign instr_addr = pc_f_q;
    assign fetch_cnt  = fetch_cnt_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: per-cycle comparison against a behavioural model plus literal spot checks.
module tb_fetch_pc_unit;

    logic        clk;
    logic        rst;
    logic        stall_f, stall_d, flush_d, pc_src_e;
    logic [31:0] pc_target_e;
    logic [31:0] instr_addr, instr_f, instr_d, pc_d, pc_plus4_d, fetch_cnt;
    logic        valid_d, halted;

    // Second instance with a reset PC near the top of the address space, free running.
    logic [31:0] w_instr_addr, w_instr_f, w_instr_d, w_pc_d, w_pc_plus4_d, w_fetch_cnt;
    logic        w_valid_d, w_halted;

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0001;
    endfunction

    assign instr_f   = mem(instr_addr);
    assign w_instr_f = mem(w_instr_addr);

    fetch_pc_unit dut (
        .clk         (clk),
        .rst         (rst),
        .stall_f     (stall_f),
        .stall_d     (stall_d),
        .flush_d     (flush_d),
        .pc_src_e    (pc_src_e),
        .pc_target_e (pc_target_e),
        .instr_addr  (instr_addr),
        .instr_f     (instr_f),
        .instr_d     (instr_d),
        .pc_d        (pc_d),
        .pc_plus4_d  (pc_plus4_d),
        .valid_d     (valid_d),
        .halted      (halted),
        .fetch_cnt   (fetch_cnt)
    );

    fetch_pc_unit #(
        .RESET_PC (32'hFFFF_FFF8)
    ) dut_wrap (
        .clk         (clk),
        .rst         (rst),
        .stall_f     (1'b0),
        .stall_d     (1'b0),
        .flush_d     (1'b0),
        .pc_src_e    (1'b0),
        .pc_target_e (32'h0),
        .instr_addr  (w_instr_addr),
        .instr_f     (w_instr_f),
        .instr_d     (w_instr_d),
        .pc_d        (w_pc_d),
        .pc_plus4_d  (w_pc_plus4_d),
        .valid_d     (w_valid_d),
        .halted      (w_halted),
        .fetch_cnt   (w_fetch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model of the architectural state.
    logic [31:0] m_pc, m_instr, m_pcd, m_pc4d, m_cnt;
    logic        m_valid, m_halt;
    bit          m_init = 0;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_pc = 32'h0; m_instr = 32'h13; m_pcd = 0; m_pc4d = 0;
                m_valid = 0; m_halt = 0; m_cnt = 0; m_init = 1;
            end else if (m_init) begin
                if (m_halt || flush_d) begin
                    m_instr = 32'h13;
                    m_valid = 0;
                end else if (!stall_d) begin
                    m_instr = mem(m_pc);
                    m_pcd   = m_pc;
                    m_pc4d  = m_pc + 32'd4;
                    m_valid = 1;
                    m_cnt   = m_cnt + 1;
                end
                if (!m_halt) begin
                    if (pc_src_e && pc_target_e[1:0] != 2'b00) m_halt = 1;
                    else if (pc_src_e)                         m_pc = pc_target_e;
                    else if (!stall_f)                         m_pc = m_pc + 32'd4;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (m_init) begin
                chk("instr_addr", instr_addr, m_pc);
                chk("instr_d", instr_d, m_instr);
                chk("pc_d", pc_d, m_pcd);
                chk("pc_plus4_d", pc_plus4_d, m_pc4d);
                chk("valid_d", {31'b0, valid_d}, {31'b0, m_valid});
                chk("halted", {31'b0, halted}, {31'b0, m_halt});
                chk("fetch_cnt", fetch_cnt, m_cnt);
            end
        end
    end

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic idle();
        stall_f = 0; stall_d = 0; flush_d = 0; pc_src_e = 0; pc_target_e = 32'h0;
    endtask

    initial begin
        rst = 1;
        idle();
        step(2);
        rst = 0;
        #1;
        chk("lit reset addr", instr_addr, 32'h0);
        chk("lit reset valid", {31'b0, valid_d}, 32'h0);
        chk("lit reset instr", instr_d, 32'h13);
        chk("lit wrap addr0", w_instr_addr, 32'hFFFF_FFF8);
        step();
        #1;
        chk("lit addr after 1", instr_addr, 32'h4);
        chk("lit valid after 1", {31'b0, valid_d}, 32'h1);
        chk("lit wrap addr1", w_instr_addr, 32'hFFFF_FFFC);
        step();
        #1;
        chk("lit wrap addr2", w_instr_addr, 32'h0);
        chk("lit wrap pc4 of FFFC", w_pc_plus4_d, 32'h0);
        step();
        #1;
        chk("lit wrap pc_d", w_pc_d, 32'h0);
        chk("lit wrap pc4 of 0", w_pc_plus4_d, 32'h4);
        step();
        // Stall both stages at PC 0x10.
        stall_f = 1; stall_d = 1;
        step(3);
        #1;
        chk("lit stall addr", instr_addr, 32'h10);
        chk("lit stall cnt", fetch_cnt, 32'd4);
        chk("lit stall pc_d", pc_d, 32'hC);
        idle();
        step();
        #1;
        chk("lit resume addr", instr_addr, 32'h14);
        // Redirect overrides stall_f, flush inserts a bubble.
        pc_src_e = 1; pc_target_e = 32'h100; stall_f = 1; flush_d = 1;
        step();
        #1;
        chk("lit redirect addr", instr_addr, 32'h100);
        chk("lit flush instr", instr_d, 32'h13);
        chk("lit flush valid", {31'b0, valid_d}, 32'h0);
        idle();
        step();
        #1;
        chk("lit target loaded", pc_d, 32'h100);
        chk("lit target instr", instr_d, mem(32'h100));
        // Flush together with stall: flush wins, counter holds.
        flush_d = 1; stall_d = 1;
        step();
        #1;
        chk("lit fs instr", instr_d, 32'h13);
        chk("lit fs valid", {31'b0, valid_d}, 32'h0);
        chk("lit fs cnt", fetch_cnt, 32'd6);
        chk("lit fs pc_d held", pc_d, 32'h100);
        idle();
        step(2);
        // Redirect while decode is stalled.
        pc_src_e = 1; pc_target_e = 32'h40; stall_d = 1;
        step();
        idle();
        step(2);
        // Misaligned redirect halts fetch.
        pc_src_e = 1; pc_target_e = 32'h102;
        step();
        #1;
        chk("lit halted", {31'b0, halted}, 32'h1);
        pc_target_e = 32'h200; stall_f = 1;
        step();
        idle();
        step(3);
        #1;
        chk("lit halt valid", {31'b0, valid_d}, 32'h0);
        chk("lit halt addr", instr_addr, 32'h48);
        rst = 1;
        step();
        rst = 0;
        #1;
        chk("lit rst halted", {31'b0, halted}, 32'h0);
        chk("lit rst addr", instr_addr, 32'h0);
        chk("lit rst cnt", fetch_cnt, 32'h0);
        step(3);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
